seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Parametrised multiplexed seven-segment scanner. It drives up to NUM_DIGITS common-anode digits from a packed hex bus, with per-digit enable, decimal points, 16-level PWM brightness, inter-digit ghost blanking and frame-synchronous (tear-free) value updates. It sits between the board pins (`cathodes`/`anodes`) and any value producer in `top`, and replaces the fixed-width single-value display path.

## Interface

Parameters:
- NUM_DIGITS, 8: digits scanned, 2..16.
- REFRESH_DIV, 100000: clocks per digit slot; 1 ms at 100 MHz. Must be at least 4.
- BLANK_CYCLES, 16: clocks at the start of each slot with all anodes off. Must be less than REFRESH_DIV.

Ports:
- clk_100MHz  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- values  in  4*NUM_DIGITS  hex nibble per digit; digit k is bits [4k+3:4k].
- dp  in  NUM_DIGITS  decimal point request per digit, active high.
- digit_en  in  NUM_DIGITS  digit visible, active high.
- load  in  1  single-cycle strobe; captures values, dp and digit_en.
- brightness  in  4  duty is (brightness+1)/16.
- cathodes  out  7  segments {g,f,e,d,c,b,a}, active low.
- dp_n  out  1  decimal point, active low.
- anodes  out  NUM_DIGITS  digit select, active low.
- frame_done  out  1  one-cycle pulse at each frame boundary.

## Operation

- **Prescaler (`presc`).** Counts 0..REFRESH_DIV-1 and wraps. `slot_tick` is asserted when `presc` equals REFRESH_DIV-1.
- **Digit index (`idx`).** Advances on `slot_tick` and wraps from NUM_DIGITS-1 to 0. The frame boundary is `slot_tick` with `idx` equal to NUM_DIGITS-1; frame_done is a registered pulse of it.
- **Double buffering.**
  - `load` writes the inputs into shadow registers and sets `pending`.
  - At a frame boundary with `pending` set, shadow is copied to active and `pending` clears.
  - If `load` coincides with a frame boundary, the inputs go directly to active and `pending` clears.
  - A later `load` before the boundary overwrites the shadow, so the last one wins.
- **PWM.** `pwm_cnt` is a 4-bit free-running counter. The anode is lit only when `pwm_cnt` is at most `brightness`. brightness=15 means always lit.
- **Anode enable.** All three of these must hold: `presc` is at least BLANK_CYCLES, the PWM condition is true, and `active_en[idx]` is set. Only anodes[idx] may be low, and at most one anode is low in any cycle.
- **Decode.** Hex to active-low segments for 0..F. Examples:
  - 0 = 1000000
  - 1 = 1111001
  - 8 = 0000000
  - A = 0001000
  - F = 0001110
- **Idle values.** dp_n is the inverse of `active_dp[idx]`. When the anode is off, cathodes are 7'h7F and dp_n is 1.
- **Brightness.** `brightness` is used live and is not buffered.

## Timing

- **Reset values.**
  - Outputs: anodes all 1, cathodes 7'h7F, dp_n 1, frame_done 0.
  - Internal state: `presc`, `idx` and `pwm_cnt` are 0. Active and shadow registers are 0, so the display is blank until the first applied load. `pending` is 0.
- **Output latency.** All outputs are registered. Each output reflects `idx`, `presc`, `pwm_cnt` and the active registers from the previous cycle.
- **Update latency.** A `load` becomes visible on the first slot of the next frame, one cycle after frame_done-source.
- **frame_done.** High exactly one cycle per NUM_DIGITS*REFRESH_DIV clocks.
- **Reset mid-operation.** Outputs return to reset values immediately (asynchronously). Any pending load is discarded.

## Structure

- **Package `seg7_pkg`:**
  - The 16-entry segment pattern constant.
  - Constants SEG_BLANK = 7'h7F and AN_OFF.
  - The `seg_t` typedef, a 7-bit logic vector.
- **Sub-module `seg7_hex_decoder`:** combinational, nibble in, `seg_t` out. The top-level scanner holds the counters, buffers and output registers.

## Test plan

Bench parameters: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=1, brightness=15.

1. **Reset.** Hold rst_n low for 3 cycles → anodes=4'hF, cathodes=7'h7F, dp_n=1, frame_done=0. After release, the display stays blank because active_en=0.
2. **Scan.** Apply values=16'hA810, digit_en=4'hF, dp=4'b0100, pulse load.
   - After the next frame boundary, the slots show anodes 1110/1101/1011/0111 with cathodes 1000000/1111001/0000000/0001000.
   - dp_n=0 only in slot 2.
   - Anodes are off in the first output cycle of each slot.
   - frame_done pulses every 32 cycles.
3. **Tear-free load.** Load 16'h1111 mid-frame → the current frame is unchanged, and the next frame shows all "1".
   - Issue two loads within one frame → only the second is displayed.
   - Issue a load on the boundary cycle → it is applied at that same boundary.
4. **Blanking and enable.** Set digit_en=4'b0101 → anodes[1] and anodes[3] are never low, and cathodes are 7'h7F during those slots.
5. **Brightness.** Set brightness=3 → anode low-time is 4/16 of the enabled cycles, ±1 per slot. Set brightness=0 → 1/16.
6. **Reset mid-frame.** Assert rst_n during slot 2 with a load pending → outputs are immediately at reset values. After release, the scan restarts at idx 0 and the display is blank.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active low.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;
  localparam logic AN_OFF    = 1'b1;

  localparam seg_t SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Value-producer side of the scanner: packed digits, per-digit flags,
// the load strobe and the live brightness level.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] values;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    load;
  logic [3:0]              brightness;

  modport master (output values, output dp, output digit_en, output load, output brightness);
  modport slave  (input  values, input  dp, input  digit_en, input  load, input  brightness);
endinterface

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scanner with PWM dimming, ghost blanking and
// frame-synchronous double-buffered updates.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk_100MHz,
  input  logic                  rst_n,
  seg7_scan_driver_if.slave     bus,
  output logic [6:0]            cathodes,
  output logic                  dp_n,
  output logic [NUM_DIGITS-1:0] anodes,
  output logic                  frame_done
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  logic [PW-1:0]           presc;
  logic [IW-1:0]           idx;
  logic [3:0]              pwm_cnt;
  logic                    slot_tick;
  logic                    frame_bnd;

  logic [4*NUM_DIGITS-1:0] shadow_val, active_val;
  logic [NUM_DIGITS-1:0]   shadow_dp, active_dp;
  logic [NUM_DIGITS-1:0]   shadow_en, active_en;
  logic                    pending;

  logic                    lit;
  seg_t                    seg_cur;

  assign slot_tick = (presc == PW'(REFRESH_DIV - 1));
  assign frame_bnd = slot_tick && (idx == IW'(NUM_DIGITS - 1));

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      idx     <= '0;
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
      presc   <= slot_tick ? '0 : presc + PW'(1);
      if (slot_tick)
        idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
    end
  end

  // A load landing on the boundary bypasses the shadow so it is not held a whole frame.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      shadow_en  <= '0;
      active_val <= '0;
      active_dp  <= '0;
      active_en  <= '0;
      pending    <= 1'b0;
    end else if (bus.load) begin
      shadow_val <= bus.values;
      shadow_dp  <= bus.dp;
      shadow_en  <= bus.digit_en;
      if (frame_bnd) begin
        active_val <= bus.values;
        active_dp  <= bus.dp;
        active_en  <= bus.digit_en;
        pending    <= 1'b0;
      end else begin
        pending    <= 1'b1;
      end
    end else if (frame_bnd && pending) begin
      active_val <= shadow_val;
      active_dp  <= shadow_dp;
      active_en  <= shadow_en;
      pending    <= 1'b0;
    end
  end

  seg7_hex_decoder u_dec (
    .nibble (active_val[{idx, 2'b00} +: 4]),
    .seg    (seg_cur)
  );

  assign lit = (presc >= PW'(BLANK_CYCLES)) && (pwm_cnt <= bus.brightness) && active_en[idx];

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      anodes     <= {NUM_DIGITS{AN_OFF}};
      cathodes   <= SEG_BLANK;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_bnd;
      if (lit) begin
        anodes   <= ~(NUM_DIGITS'(1) << idx);
        cathodes <= seg_cur;
        dp_n     <= ~active_dp[idx];
      end else begin
        anodes   <= {NUM_DIGITS{AN_OFF}};
        cathodes <= SEG_BLANK;
        dp_n     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized and directed bench for seg7_scan_driver; expected outputs come
// from a cycle-count model of the scan timing and the double-buffer rules.
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int RD = 8;
  localparam int BL = 1;
  localparam int FRAME = N * RD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [6:0]   cathodes;
  logic         dp_n;
  logic [N-1:0] anodes;
  logic         frame_done;

  seg7_scan_driver_if #(.NUM_DIGITS(N)) bus ();

  seg7_scan_driver #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BL)
  ) dut (
    .clk_100MHz (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .cathodes   (cathodes),
    .dp_n       (dp_n),
    .anodes     (anodes),
    .frame_done (frame_done)
  );

  logic [6:0] seg_ref [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  int           t;
  logic [15:0]  m_val, s_val;
  logic [3:0]   m_dp, s_dp, m_en, s_en;
  bit           m_pend;
  int           vectors, miscompares, lit_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    t = 0;
    m_val = '0; m_dp = '0; m_en = '0;
    s_val = '0; s_dp = '0; s_en = '0;
    m_pend = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_anodes", anodes, 4'hF);
    check("rst_cathodes", cathodes, 7'h7F);
    check("rst_dp_n", dp_n, 1'b1);
    check("rst_frame_done", frame_done, 1'b0);
  endtask

  // One clock: predict from the cycle count, apply the load rules, compare.
  task automatic step();
    int pr, id, pw;
    bit bnd, lit;
    logic [3:0] ean;
    logic [6:0] ecat;
    logic edp;
    pr  = t % RD;
    id  = (t / RD) % N;
    pw  = t % 16;
    bnd = (pr == RD - 1) && (id == N - 1);
    lit = (pr >= BL) && (pw <= int'(bus.brightness)) && m_en[id];
    ean  = lit ? ~(4'b0001 << id) : 4'hF;
    ecat = lit ? seg_ref[m_val[4*id +: 4]] : 7'h7F;
    edp  = lit ? ~m_dp[id] : 1'b1;
    if (bus.load) begin
      if (bnd) begin
        m_val = bus.values; m_dp = bus.dp; m_en = bus.digit_en; m_pend = 1'b0;
      end else begin
        s_val = bus.values; s_dp = bus.dp; s_en = bus.digit_en; m_pend = 1'b1;
      end
    end else if (bnd && m_pend) begin
      m_val = s_val; m_dp = s_dp; m_en = s_en; m_pend = 1'b0;
    end
    t++;
    @(posedge clk);
    #1;
    check("anodes", anodes, ean);
    check("cathodes", cathodes, ecat);
    check("dp_n", dp_n, edp);
    check("frame_done", frame_done, bnd);
    check("one_hot", ($countones(~anodes) <= 1), 1'b1);
    if (anodes != 4'hF) lit_cnt++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic to_phase(input int ph);
    while ((t % FRAME) != ph) step();
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
    bus.values = v; bus.dp = d; bus.digit_en = e; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vectors = 0; miscompares = 0; lit_cnt = 0;
    bus.values = '0; bus.dp = '0; bus.digit_en = '0; bus.load = 1'b0; bus.brightness = 4'd15;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    run(40);

    // Basic scan of A810 with a decimal point on digit 2.
    pulse_load(16'hA810, 4'b0100, 4'hF);
    run(3 * FRAME);

    // Mid-frame load must wait for the boundary.
    to_phase(10);
    pulse_load(16'h1111, 4'b0000, 4'hF);
    run(2 * FRAME);

    // Two loads in one frame: the second wins.
    to_phase(5);
    pulse_load(16'($urandom), 4'($urandom), 4'hF);
    run(7);
    pulse_load(16'($urandom), 4'($urandom), 4'hF);
    run(2 * FRAME);

    // Load on the boundary cycle takes effect at that boundary.
    to_phase(FRAME - 1);
    pulse_load(16'h2345, 4'b1001, 4'hF);
    run(FRAME + 8);

    // Disabled digits stay dark.
    pulse_load(16'($urandom), 4'($urandom), 4'b0101);
    run(3 * FRAME);

    // Brightness duty checks.
    pulse_load(16'h8888, 4'b0000, 4'hF);
    to_phase(0);
    bus.brightness = 4'd3;
    lit_cnt = 0;
    run(2 * FRAME);
    check("duty_b3", (lit_cnt >= 6) && (lit_cnt <= 22), 1'b1);
    bus.brightness = 4'd0;
    lit_cnt = 0;
    run(2 * FRAME);
    check("duty_b0", (lit_cnt <= 8), 1'b1);
    bus.brightness = 4'd15;
    lit_cnt = 0;
    run(2 * FRAME);
    check("duty_b15", (lit_cnt == 2 * N * (RD - BL)), 1'b1);

    // Randomized loads, gaps and brightness.
    for (int k = 0; k < 12; k++) begin
      bus.brightness = 4'($urandom);
      pulse_load(16'($urandom), 4'($urandom), 4'($urandom));
      run(int'($urandom_range(1, 40)));
    end
    bus.brightness = 4'd15;
    run(FRAME);

    // Reset during slot 2 with a load pending.
    to_phase(17);
    pulse_load(16'hFFFF, 4'hF, 4'hF);
    run(1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    lit_cnt = 0;
    run(2 * FRAME);
    check("blank_after_rst", lit_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
